// File: rtl/sfifo_rd_stream_if.sv
// sfifo_rd_stream_if: FIFO read port plus the outgoing valid/ready stream.
// master = the adapter (drives fifo_re and the stream), slave = its environment.
interface sfifo_rd_stream_if #(
    parameter int DWIDTH = 32,
    parameter int RD_LAT = 1
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              fifo_empty;
    logic              fifo_re;
    logic [DWIDTH-1:0] fifo_rdata;
    logic              o_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] o_data;
    logic [CW-1:0]     o_level;
    logic [31:0]       o_beats;

    modport master (
        input  fifo_empty, fifo_rdata, o_ready,
        output fifo_re, o_valid, o_data, o_level, o_beats
    );

    modport slave (
        output fifo_empty, fifo_rdata, o_ready,
        input  fifo_re, o_valid, o_data, o_level, o_beats
    );
endinterface

// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: turns a synchronous FIFO read port (data RD_LAT cycles
// after re) into a valid/ready stream with a credit-managed skid buffer of
// RD_LAT+2 entries. fifo_re depends only on buffer level + reads in flight,
// never on o_ready.
// Optional accepted-beat counter on o_beats: define SFIFO_RDS_BEATCNT_EN.
module sfifo_rd_stream #(
    parameter int DWIDTH = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sfifo_rd_stream_if.master   bus
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int TW    = CW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_pipe;
    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    logic [CW-1:0]     r_level;

    logic [CW-1:0]     w_inflight;
    logic [TW-1:0]     w_total;
    logic              w_re;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    // Wrap modulo DEPTH; DEPTH is generally not a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // Count reads already issued whose data has not yet landed.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    assign w_total = TW'(r_level) + TW'(w_inflight);
    assign w_re    = rst_n & ~bus.fifo_empty & (w_total < TW'(DEPTH));
    assign w_push  = r_pipe[RD_LAT-1];
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & bus.o_ready;

    // Read-valid pipe tracking fifo_re until its data arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_re;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Capture returning read data into the skid buffer (array not reset).
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= bus.fifo_rdata;
        end
    end

    // Pointer and level bookkeeping for push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SFIFO_RDS_BEATCNT_EN
    logic [31:0] r_beats;

    // Free-running count of accepted beats, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beats <= '0;
        end else if (w_pop) begin
            r_beats <= r_beats + 32'd1;
        end
    end

    assign bus.o_beats = r_beats;
`else
    assign bus.o_beats = '0;
`endif

    assign bus.fifo_re = w_re;
    assign bus.o_valid = w_valid;
    assign bus.o_data  = r_mem[r_rd_ptr];
    assign bus.o_level = r_level;

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// tb_sfifo_rd_stream: directed + random checks of sfifo_rd_stream at
// RD_LAT = 1..4 in parallel lanes sharing the same stimulus. The upstream
// FIFO model returns its read index as data, so the stream must carry
// 0,1,2,... in order after each reset.
module tb_sfifo_rd_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_empty = 1'b1;
    logic r_ready = 1'b0;

    always #5 clk = ~clk;

    logic        w_re    [4];
    logic        w_valid [4];
    logic [31:0] w_data  [4];
    logic [31:0] w_beats [4];
    logic [31:0] w_rdc   [4];
    logic [3:0]  w_level [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam int L = k + 1;
        sfifo_rd_stream_if #(.DWIDTH(32), .RD_LAT(L)) bus ();
        logic [31:0] rd_cnt;
        logic [31:0] pd [1:4];

        sfifo_rd_stream #(.DWIDTH(32), .RD_LAT(L)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.fifo_empty = r_empty;
        assign bus.o_ready    = r_ready;
        assign bus.fifo_rdata = pd[L];

        // Upstream FIFO model: data for a read appears L cycles later.
        always @(posedge clk) begin
            if (!rst_n) rd_cnt <= '0;
            else if (bus.fifo_re) rd_cnt <= rd_cnt + 32'd1;
            pd[1] <= rd_cnt;
            for (int i = 2; i <= 4; i++) pd[i] <= pd[i-1];
        end

        assign w_re[k]    = bus.fifo_re;
        assign w_valid[k] = bus.o_valid;
        assign w_data[k]  = bus.o_data;
        assign w_beats[k] = bus.o_beats;
        assign w_rdc[k]   = rd_cnt;
        assign w_level[k] = 4'(bus.o_level);
    end

    int nchk = 0;
    int nfail = 0;

    int          exp_w [4];
    int          pops  [4];
    logic        pv    [4];
    logic [31:0] pdat  [4];
    int          recnt [4];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Per-cycle scoreboard, stability, bound and beat-count checks (at negedge).
    task automatic mon();
        for (int k = 0; k < 4; k++) begin
`ifdef SFIFO_RDS_BEATCNT_EN
            check($sformatf("beats L%0d", k+1), w_beats[k], pops[k]);
`else
            check($sformatf("beats L%0d", k+1), w_beats[k], 0);
`endif
            check($sformatf("level_bound L%0d", k+1), (w_level[k] <= 4'(k+3)), 1);
            if (pv[k]) begin
                check($sformatf("hold_valid L%0d", k+1), w_valid[k], 1);
                check($sformatf("hold_data L%0d", k+1), w_data[k], pdat[k]);
            end
            if (w_valid[k] && r_ready) begin
                check($sformatf("data L%0d", k+1), w_data[k], exp_w[k]);
                exp_w[k]++;
                pops[k]++;
            end
            pv[k]   = w_valid[k] && !r_ready;
            pdat[k] = w_data[k];
        end
    endtask

    task automatic end_cycle();
        mon();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles with the FIFO non-empty; fifo_re must stay low.
    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        r_empty = 1'b0;
        r_ready = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) check($sformatf("rst_re L%0d", k+1), w_re[k], 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w[k] = 0;
            pops[k]  = 0;
            pv[k]    = 1'b0;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        // Idle after reset with an empty FIFO.
        r_empty = 1'b1;
        r_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("idle_re L%0d", k+1), w_re[k], 0);
                check($sformatf("idle_valid L%0d", k+1), w_valid[k], 0);
                check($sformatf("idle_level L%0d", k+1), w_level[k], 0);
            end
            end_cycle();
        end

        // 16-word burst with sink always ready: latency RD_LAT+1, no gaps.
        for (int c = 0; c < 24; c++) begin
            r_empty = (c >= 16);
            r_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("burst_re c%0d L%0d", c, k+1), w_re[k], (c < 16));
                check($sformatf("burst_valid c%0d L%0d", c, k+1), w_valid[k],
                      (c >= k+2) && (c < k+18));
            end
            end_cycle();
        end

        // Back-pressure: exactly DEPTH reads, buffer fills to DEPTH.
        for (int k = 0; k < 4; k++) recnt[k] = 0;
        for (int c = 0; c < 15; c++) begin
            r_empty = 1'b0;
            r_ready = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 4; k++) recnt[k] += int'(w_re[k]);
            end_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_re_count L%0d", k+1), recnt[k], k+3);
            check($sformatf("bp_level L%0d", k+1), w_level[k], k+3);
        end

        // Release back-pressure: continuous flow with no gap.
        for (int c = 0; c < 30; c++) begin
            r_empty = 1'b0;
            r_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                check($sformatf("flow_valid c%0d L%0d", c, k+1), w_valid[k], 1);
            end_cycle();
        end

        // Build up buffered and in-flight words, then reset for one cycle.
        for (int c = 0; c < 3; c++) begin
            r_empty = 1'b0;
            r_ready = 1'b0;
            @(negedge clk);
            end_cycle();
        end
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            r_empty = 1'b1;
            r_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("post_rst_valid L%0d", k+1), w_valid[k], 0);
                check($sformatf("post_rst_level L%0d", k+1), w_level[k], 0);
            end
            end_cycle();
        end

        // Random back-pressure and FIFO emptiness.
        for (int c = 0; c < 20000; c++) begin
            r_ready = 1'($urandom_range(0, 1));
            r_empty = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            end_cycle();
        end

        // Drain: every word read from the FIFO must have been delivered.
        r_empty = 1'b1;
        r_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            end_cycle();
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_count L%0d", k+1), exp_w[k], w_rdc[k]);
            check($sformatf("drain_level L%0d", k+1), w_level[k], 0);
            check($sformatf("drain_valid L%0d", k+1), w_valid[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
